seq_trojan_node_payload: RTL and testbench
==========================================

Name: seq_trojan_node_payload

Overview:
- Parametrised sequential successor to our combinational single-node trojan insertions in the ISCAS benchmark set.
- Sits in series on one victim net of a host netlist, e.g. between a NAND2 output and its fan-out.
- Monitors a WIDTH-bit trigger bus for a rare masked pattern and counts distinct occurrences.
- Once a threshold is reached, corrupts the victim net using a selectable payload for a bounded or permanent window. Used to generate time-bomb trojan patterns for detection experiments.

Parameters:
- WIDTH, 5: trigger bus width (host primary inputs or internal nets).
- TRIG_PATTERN, 5'b10101: trigger value compared on masked bits.
- TRIG_MASK, 5'b11111: 1 = bit participates in compare; all-zero mask means every enabled cycle matches.
- CNT_W, 4: event counter width.
- THRESH, 8: event count that fires the trojan; legal range 1..2^CNT_W-1.
- PAYLOAD_MODE, 0: 0 = invert victim, 1 = stuck-at-0, 2 = stuck-at-1, 3 = XOR victim with trig_in[0].
- HOLD_CYCLES, 0: 0 = payload permanent until clear/reset; N>0 = payload active N cycles, then re-arm.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  trigger monitor enable; 0 freezes counting (payload state unaffected).
- tj_clear  input  1  synchronous clear: counter to 0, state to IDLE.
- trig_in  input  WIDTH  trigger observation bus.
- victim_in  input  1  original victim net value.
- victim_out  output  1  net value driven to fan-out.
- armed  output  1  counter nonzero and payload not active.
- active  output  1  payload currently applied.
- fired  output  1  sticky: payload activated at least once since reset.
- event_count  output  CNT_W  current event count.

Behaviour:
- Reset (async, rst_n=0): state IDLE, event_count=0, match_q=0, hold counter=0, armed=0, active=0, fired=0. victim_out=victim_in immediately; it is combinational pass-through.
- match = en & ((trig_in & TRIG_MASK) == (TRIG_PATTERN & TRIG_MASK)). match_q registers match every cycle.
- Event = match & ~match_q (rising edge of match). A pattern held N cycles counts once. en=0 forces match=0, so re-enabling while the pattern is present counts a new event.
- States:
  - IDLE: on event, event_count=1; go to COUNT, or to ACTIVE if THRESH==1.
  - COUNT: on event, event_count+1. When the incremented value equals THRESH, go to ACTIVE the same edge; event_count holds THRESH.
  - ACTIVE: active=1, fired set. Events ignored; event_count frozen.
    - HOLD_CYCLES=0: remain in ACTIVE until tj_clear or reset.
    - HOLD_CYCLES>0: hold counter loads HOLD_CYCLES-1 on entry and decrements. At 0, next edge returns to IDLE with event_count=0. Total active window is exactly HOLD_CYCLES cycles.
- victim_out is combinational from registered state:
  - active=0: victim_in.
  - active=1: mode 0 ~victim_in; mode 1 0; mode 2 1; mode 3 victim_in^trig_in[0].
- Payload latency: active rises on the clock edge that registers the THRESH-th event. victim_out is corrupted from that edge onward, with no extra pipeline delay.
- armed = (state==COUNT).
- tj_clear has priority over event and hold expiry in the same cycle. It returns to IDLE with event_count=0 and match_q updated normally; fired is not cleared.
- Reset asserted mid-ACTIVE drops active and victim_out to pass-through asynchronously.
- Counter never wraps, because THRESH ≤ 2^CNT_W-1. An out-of-range THRESH is an elaboration error (generate-time check).

Test Plan:
- Reset/pass-through: rst_n=0 then 1, toggle victim_in with non-matching trig_in=5'b00000 for 20 cycles → victim_out==victim_in, event_count=0, active=0, fired=0.
- Edge counting: hold trig_in=5'b10101 for 5 cycles, then 5'b00000 → event_count=1, armed=1. Repeat pulses to 7 events → event_count=7, active=0.
- Fire, mode 0, permanent: 8th pulse → active=1 on that edge, victim_out=~victim_in. Further pulses leave event_count=8. active stays 1 for 100 cycles. tj_clear → active=0, event_count=0, fired=1.
- Bounded hold: HOLD_CYCLES=3, PAYLOAD_MODE=2, THRESH=2 → after 2nd pulse victim_out=1 for exactly 3 cycles, then pass-through, state IDLE. A 2-pulse sequence refires.
- Priority/enable: tj_clear coincident with the 8th event → no fire, event_count=0. en=0 while pattern present → no count. Raising en with pattern present → count+1.
- Async reset mid-payload: rst_n=0 while active=1, between clock edges → active, fired, event_count drop to 0 before the next edge; victim_out follows victim_in.

Source files
------------

// File: rtl/seq_trojan_node_payload.sv
// Sequential time-bomb trojan sitting in series on one victim net.
// Counts rising edges of a masked trigger match and corrupts the net once THRESH events are seen.
module seq_trojan_node_payload #(
   parameter int               WIDTH        = 5,
   parameter logic [WIDTH-1:0] TRIG_PATTERN = 5'b10101,
   parameter logic [WIDTH-1:0] TRIG_MASK    = 5'b11111,
   parameter int               CNT_W        = 4,
   parameter int               THRESH       = 8,
   parameter int               PAYLOAD_MODE = 0,
   parameter int               HOLD_CYCLES  = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             tj_clear,
   input  logic [WIDTH-1:0] trig_in,
   input  logic             victim_in,
   output logic             victim_out,
   output logic             armed,
   output logic             active,
   output logic             fired,
   output logic [CNT_W-1:0] event_count
);

   localparam int               HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

   generate
      if (THRESH < 1 || THRESH > (2 ** CNT_W) - 1) begin : g_thresh_check
         $error("seq_trojan_node_payload: THRESH outside 1..2^CNT_W-1");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_COUNT  = 2'd1,
      S_ACTIVE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic [HOLD_W-1:0]  hold_reg, hold_next;
   logic               match_q;
   logic               fired_reg;
   logic               match;
   logic               event_hit;
   logic               corrupt;

   assign match     = en & ((trig_in & TRIG_MASK) == (TRIG_PATTERN & TRIG_MASK));
   assign event_hit = match & ~match_q;

   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      hold_next  = hold_reg;
      if (tj_clear) begin
         state_next = S_IDLE;
         count_next = '0;
         hold_next  = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (event_hit) begin
                  count_next = CNT_W'(1);
                  if (THRESH == 1) begin
                     state_next = S_ACTIVE;
                     hold_next  = HOLD_LOAD;
                  end else begin
                     state_next = S_COUNT;
                  end
               end
            end
            S_COUNT: begin
               if (event_hit) begin
                  count_next = count_reg + 1'b1;
                  if (count_reg + 1'b1 == THRESH_C) begin
                     state_next = S_ACTIVE;
                     hold_next  = HOLD_LOAD;
                  end
               end
            end
            S_ACTIVE: begin
               // A zero HOLD_CYCLES keeps the payload on until clear or reset
               if (HOLD_CYCLES != 0) begin
                  if (hold_reg == '0) begin
                     state_next = S_IDLE;
                     count_next = '0;
                  end else begin
                     hold_next = hold_reg - 1'b1;
                  end
               end
            end
            default: begin
               state_next = S_IDLE;
               count_next = '0;
               hold_next  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         count_reg <= '0;
         hold_reg  <= '0;
         match_q   <= 1'b0;
         fired_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         hold_reg  <= hold_next;
         match_q   <= match;
         fired_reg <= fired_reg | (state_next == S_ACTIVE);
      end
   end

   generate
      if (PAYLOAD_MODE == 1) begin : g_stuck0
         assign corrupt = 1'b0;
      end else if (PAYLOAD_MODE == 2) begin : g_stuck1
         assign corrupt = 1'b1;
      end else if (PAYLOAD_MODE == 3) begin : g_xor
         assign corrupt = victim_in ^ trig_in[0];
      end else begin : g_invert
         assign corrupt = ~victim_in;
      end
   endgenerate

   assign active      = (state_reg == S_ACTIVE);
   assign armed       = (state_reg == S_COUNT);
   assign fired       = fired_reg;
   assign event_count = count_reg;
   assign victim_out  = active ? corrupt : victim_in;

endmodule

// File: tb/tb_seq_trojan_node_payload.sv
// Bench for seq_trojan_node_payload: a permanent invert instance and a bounded stuck-at-1 instance.
module tb_seq_trojan_node_payload;

   localparam logic [4:0] PAT  = 5'b10101;
   localparam logic [4:0] ZERO = 5'b00000;

   logic       clk;
   logic       rst_n;
   logic       en_a, clr_a, victim_a;
   logic [4:0] trig_a;
   logic       vout_a, armed_a, active_a, fired_a;
   logic [3:0] cnt_a;
   logic       en_b, clr_b, victim_b;
   logic [4:0] trig_b;
   logic       vout_b, armed_b, active_b, fired_b;
   logic [3:0] cnt_b;

   int total = 0;
   int bad   = 0;

   seq_trojan_node_payload dut_a (
      .clk(clk), .rst_n(rst_n), .en(en_a), .tj_clear(clr_a), .trig_in(trig_a),
      .victim_in(victim_a), .victim_out(vout_a), .armed(armed_a), .active(active_a),
      .fired(fired_a), .event_count(cnt_a)
   );

   seq_trojan_node_payload #(.THRESH(2), .PAYLOAD_MODE(2), .HOLD_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en_b), .tj_clear(clr_b), .trig_in(trig_b),
      .victim_in(victim_b), .victim_out(vout_b), .armed(armed_b), .active(active_b),
      .fired(fired_b), .event_count(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] trig;
      logic       en;
      logic       clr;
      int         reps;
      int         cnt;
      bit         armed;
      bit         act;
      bit         fired;
   } vec_t;

   typedef struct {
      int cnt;
      bit armed;
      bit act;
      bit fired;
      bit vout;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic void add(logic [4:0] trig, logic en, logic clr, int reps,
                               int cnt, bit armed, bit act, bit fired);
      vec_t v;
      v.trig = trig; v.en = en; v.clr = clr; v.reps = reps;
      v.cnt = cnt; v.armed = armed; v.act = act; v.fired = fired;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, int actual, int required);
      total++;
      if (actual != required) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   task automatic chk_all(string tag, int cnt, logic arm, logic act, logic fir, logic vo, exp_t e);
      chk({tag, "_cnt"}, cnt, e.cnt);
      chk({tag, "_armed"}, int'(arm), int'(e.armed));
      chk({tag, "_active"}, int'(act), int'(e.act));
      chk({tag, "_fired"}, int'(fir), int'(e.fired));
      chk({tag, "_vout"}, int'(vo), int'(e.vout));
   endtask

   task automatic pop_cmp(string tag, bit is_b);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb.pop_front();
         if (is_b) chk_all(tag, int'(cnt_b), armed_b, active_b, fired_b, vout_b, e);
         else      chk_all(tag, int'(cnt_a), armed_a, active_a, fired_a, vout_a, e);
      end
      $display("%s: cnt_a=%0d act_a=%0b cnt_b=%0d act_b=%0b vout_b=%0b",
               tag, cnt_a, active_a, cnt_b, active_b, vout_b);
   endtask

   // One cycle on instance B: drive, queue the expected post-edge state, compare after the edge
   task automatic step_b(string tag, logic [4:0] trig, logic vic,
                         int cnt, bit arm, bit act, bit fir, bit vo);
      exp_t e;
      trig_b = trig; victim_b = vic;
      e.cnt = cnt; e.armed = arm; e.act = act; e.fired = fir; e.vout = vo;
      sb.push_back(e);
      @(posedge clk); #1;
      pop_cmp(tag, 1'b1);
   endtask

   initial begin
      exp_t e;
      rst_n = 1'b0;
      en_a = 1'b1; clr_a = 1'b0; trig_a = ZERO; victim_a = 1'b0;
      en_b = 1'b1; clr_b = 1'b0; trig_b = ZERO; victim_b = 1'b0;
      #1;
      chk("rst_a_cnt", int'(cnt_a), 0);
      chk("rst_a_active", int'(active_a), 0);
      chk("rst_a_fired", int'(fired_a), 0);
      chk("rst_b_armed", int'(armed_b), 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         victim_a = logic'($urandom_range(0, 1));
         @(posedge clk); #1;
         chk($sformatf("pass%0d_vout", i), int'(vout_a), int'(victim_a));
      end
      chk("pass_cnt", int'(cnt_a), 0);
      chk("pass_active", int'(active_a), 0);
      chk("pass_fired", int'(fired_a), 0);

      add(PAT, 1, 0, 5, 1, 1, 0, 0);
      add(ZERO, 1, 0, 1, 1, 1, 0, 0);
      for (int k = 2; k <= 7; k++) begin
         add(PAT, 1, 0, 1, k, 1, 0, 0);
         add(ZERO, 1, 0, 1, k, 1, 0, 0);
      end
      add(PAT, 1, 0, 1, 8, 0, 1, 1);
      add(ZERO, 1, 0, 1, 8, 0, 1, 1);
      add(PAT, 1, 0, 1, 8, 0, 1, 1);
      add(ZERO, 1, 0, 100, 8, 0, 1, 1);
      add(ZERO, 1, 1, 1, 0, 0, 0, 1);
      for (int k = 1; k <= 7; k++) begin
         add(PAT, 1, 0, 1, k, 1, 0, 1);
         add(ZERO, 1, 0, 1, k, 1, 0, 1);
      end
      add(PAT, 1, 1, 1, 0, 0, 0, 1);
      add(PAT, 1, 0, 1, 0, 0, 0, 1);
      add(ZERO, 1, 0, 1, 0, 0, 0, 1);
      add(PAT, 0, 0, 3, 0, 0, 0, 1);
      add(PAT, 1, 0, 1, 1, 1, 0, 1);
      add(ZERO, 1, 0, 1, 1, 1, 0, 1);
      for (int k = 2; k <= 8; k++) begin
         add(PAT, 1, 0, 1, k, k != 8, k == 8, 1);
         add(ZERO, 1, 0, 1, k, k != 8, k == 8, 1);
      end

      foreach (vecs[i]) begin
         for (int r = 0; r < vecs[i].reps; r++) begin
            trig_a = vecs[i].trig; en_a = vecs[i].en; clr_a = vecs[i].clr;
            victim_a = logic'($urandom_range(0, 1));
            if (r == vecs[i].reps - 1) begin
               e.cnt = vecs[i].cnt; e.armed = vecs[i].armed;
               e.act = vecs[i].act; e.fired = vecs[i].fired;
               e.vout = vecs[i].act ? ~victim_a : victim_a;
               sb.push_back(e);
            end
            @(posedge clk); #1;
            if (r == vecs[i].reps - 1) pop_cmp($sformatf("vec%0d", i), 1'b0);
         end
      end
      clr_a = 1'b0; en_a = 1'b1; trig_a = ZERO;

      #3 rst_n = 1'b0;
      #1;
      chk("async_active", int'(active_a), 0);
      chk("async_fired", int'(fired_a), 0);
      chk("async_cnt", int'(cnt_a), 0);
      chk("async_vout0", int'(vout_a), int'(victim_a));
      victim_a = ~victim_a;
      #1;
      chk("async_vout1", int'(vout_a), int'(victim_a));
      $display("async reset: act_a=%0b fired_a=%0b cnt_a=%0d", active_a, fired_a, cnt_a);
      @(posedge clk); #1 rst_n = 1'b1;

      step_b("b_p1", PAT, 1'b0, 1, 1, 0, 0, 0);
      step_b("b_z1", ZERO, 1'b0, 1, 1, 0, 0, 0);
      step_b("b_fire", PAT, 1'b0, 2, 0, 1, 1, 1);
      step_b("b_hold1", ZERO, 1'b0, 2, 0, 1, 1, 1);
      step_b("b_hold2", ZERO, 1'b0, 2, 0, 1, 1, 1);
      step_b("b_expire", ZERO, 1'b0, 0, 0, 0, 1, 0);
      step_b("b_idle", ZERO, 1'b1, 0, 0, 0, 1, 1);
      step_b("b_rp1", PAT, 1'b0, 1, 1, 0, 1, 0);
      step_b("b_rz1", ZERO, 1'b0, 1, 1, 0, 1, 0);
      step_b("b_refire", PAT, 1'b0, 2, 0, 1, 1, 1);
      step_b("b_rhold1", ZERO, 1'b1, 2, 0, 1, 1, 1);
      step_b("b_rhold2", ZERO, 1'b0, 2, 0, 1, 1, 1);
      step_b("b_rexpire", ZERO, 1'b0, 0, 0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
